// File: rtl/l2_sio_resp_chk.sv
// l2_sio_resp_chk
// Monitors every L2 bank's response stream toward SIO. Each bank runs a small
// IDLE/DATA framer that separates read responses (header + BEATS data beats)
// from header-only acks, checks per-beat half-word parity and framing, and
// posts at most one event per cycle into a one-entry slot. A round-robin
// arbiter presents one slot at a time on the evt_* valid/ready interface.
//
// Ports
//   iol2clk, rst_l  : clock, asynchronous active-low reset
//   mon_en          : low holds every framer in IDLE and suppresses new events
//   l2b_ctag_vld    : per-bank header strobe
//   l2b_data        : per-bank data, bank i at [i*DATA_W +: DATA_W]
//   l2b_parity      : per-bank parity, bit0 low half, bit1 high half
//   l2b_ue_err      : per-bank uncorrectable-error strobe
//   evt_vld/evt_rdy : event handshake
//   evt_bank/code/hdr : source bank, event code, captured header
//   rd_cnt, ack_cnt : saturating completion counters
//   evt_ovf         : sticky per-bank dropped-event flag
module l2_sio_resp_chk #(
    parameter int NUM_BANKS = 8,
    parameter int DATA_W    = 32,
    parameter int BEATS     = 16,
    parameter int ACK_BIT   = 31,
    parameter int CNT_W     = 16,
    localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                          iol2clk,
    input  logic                          rst_l,
    input  logic                          mon_en,
    input  logic [NUM_BANKS-1:0]          l2b_ctag_vld,
    input  logic [NUM_BANKS*DATA_W-1:0]   l2b_data,
    input  logic [NUM_BANKS*2-1:0]        l2b_parity,
    input  logic [NUM_BANKS-1:0]          l2b_ue_err,
    output logic                          evt_vld,
    input  logic                          evt_rdy,
    output logic [BANK_W-1:0]             evt_bank,
    output logic [2:0]                    evt_code,
    output logic [DATA_W-1:0]             evt_hdr,
    output logic [CNT_W-1:0]              rd_cnt,
    output logic [CNT_W-1:0]              ack_cnt,
    output logic [NUM_BANKS-1:0]          evt_ovf
);

    localparam int BCNT_W = $clog2(BEATS + 1);
    localparam int HALF   = DATA_W / 2;
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(BEATS - 1);

    localparam logic [2:0] C_RD_DONE   = 3'd0;
    localparam logic [2:0] C_ACK_DONE  = 3'd1;
    localparam logic [2:0] C_PAR_ERR   = 3'd2;
    localparam logic [2:0] C_UE_ERR    = 3'd3;
    localparam logic [2:0] C_PROTO_ERR = 3'd4;

    typedef enum logic {ST_IDLE, ST_DATA} state_t;

    logic [NUM_BANKS-1:0]        slot_vld;
    logic [NUM_BANKS*3-1:0]      slot_code_flat;
    logic [NUM_BANKS*DATA_W-1:0] slot_hdr_flat;
    logic [NUM_BANKS-1:0]        rd_done_vec;
    logic [NUM_BANKS-1:0]        ack_done_vec;
    logic [NUM_BANKS-1:0]        drain_vec;

    // ---------------- per-bank framer + event slot ----------------
    for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        state_t              state_q, state_d;
        logic [BCNT_W-1:0]   beat_q, beat_d;
        logic [DATA_W-1:0]   hdr_q, hdr_d;
        logic                slot_vld_q, slot_vld_d;
        logic [2:0]          slot_code_q, slot_code_d;
        logic [DATA_W-1:0]   slot_hdr_q, slot_hdr_d;
        logic                ovf_q, ovf_d;
        logic [DATA_W-1:0]   data;
        logic [1:0]          par, exp_par;
        logic                proto, ue, par_err, rd_done, ack_done, raise;
        logic [2:0]          code;

        assign data    = l2b_data[gi*DATA_W +: DATA_W];
        assign par     = l2b_parity[gi*2 +: 2];
        assign exp_par = {^data[DATA_W-1:HALF], ^data[HALF-1:0]};

        always_comb begin
            state_d  = state_q;
            beat_d   = beat_q;
            hdr_d    = hdr_q;
            proto    = 1'b0;
            ue       = 1'b0;
            par_err  = 1'b0;
            rd_done  = 1'b0;
            ack_done = 1'b0;
            if (!mon_en) begin
                // Any in-flight response is dropped without an event or count.
                state_d = ST_IDLE;
                beat_d  = '0;
            end else begin
                ue = l2b_ue_err[gi];
                if (l2b_ctag_vld[gi]) begin
                    // A header in DATA abandons the current response and the
                    // new header is framed exactly as if it arrived in IDLE.
                    proto  = (state_q == ST_DATA);
                    hdr_d  = data;
                    beat_d = '0;
                    if (data[ACK_BIT]) begin
                        ack_done = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_DATA;
                    end
                end else if (state_q == ST_DATA) begin
                    par_err = (par != exp_par);
                    if (beat_q == LAST_BEAT) begin
                        rd_done = 1'b1;
                        state_d = ST_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d  = beat_q + BCNT_W'(1);
                    end
                end
            end
        end

        always_comb begin
            raise = proto | ue | par_err | rd_done | ack_done;
            if (proto)        code = C_PROTO_ERR;
            else if (ue)      code = C_UE_ERR;
            else if (par_err) code = C_PAR_ERR;
            else if (rd_done) code = C_RD_DONE;
            else              code = C_ACK_DONE;
        end

        always_comb begin
            slot_vld_d  = slot_vld_q;
            slot_code_d = slot_code_q;
            slot_hdr_d  = slot_hdr_q;
            ovf_d       = ovf_q;
            if (drain_vec[gi]) slot_vld_d = 1'b0;
            if (raise) begin
                // A drain in the same cycle frees the slot for the new event.
                if (slot_vld_q && !drain_vec[gi]) begin
                    ovf_d = 1'b1;
                end else begin
                    slot_vld_d  = 1'b1;
                    slot_code_d = code;
                    slot_hdr_d  = hdr_d;
                end
            end
        end

        always_ff @(posedge iol2clk or negedge rst_l) begin
            if (!rst_l) begin
                state_q     <= ST_IDLE;
                beat_q      <= '0;
                hdr_q       <= '0;
                slot_vld_q  <= 1'b0;
                slot_code_q <= '0;
                slot_hdr_q  <= '0;
                ovf_q       <= 1'b0;
            end else begin
                state_q     <= state_d;
                beat_q      <= beat_d;
                hdr_q       <= hdr_d;
                slot_vld_q  <= slot_vld_d;
                slot_code_q <= slot_code_d;
                slot_hdr_q  <= slot_hdr_d;
                ovf_q       <= ovf_d;
            end
        end

        assign slot_vld[gi]                      = slot_vld_q;
        assign slot_code_flat[gi*3 +: 3]         = slot_code_q;
        assign slot_hdr_flat[gi*DATA_W +: DATA_W] = slot_hdr_q;
        assign rd_done_vec[gi]                   = rd_done;
        assign ack_done_vec[gi]                  = ack_done;
        assign evt_ovf[gi]                       = ovf_q;
    end

    // ---------------- round-robin arbiter ----------------
    logic [BANK_W-1:0] ptr_q, ptr_d;
    logic [BANK_W-1:0] win;
    logic              found;
    logic              hs;

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int off = 0; off < NUM_BANKS; off++) begin
            int idx;
            idx = (int'(ptr_q) + off) % NUM_BANKS;
            if (!found && slot_vld[idx]) begin
                found = 1'b1;
                win   = BANK_W'(idx);
            end
        end
    end

    always_comb begin
        evt_vld  = found;
        evt_bank = found ? win : '0;
        evt_code = found ? slot_code_flat[win*3 +: 3] : 3'd0;
        evt_hdr  = found ? slot_hdr_flat[win*DATA_W +: DATA_W] : '0;
        hs        = found && evt_rdy;
        drain_vec = hs ? (NUM_BANKS'(1) << win) : '0;
        ptr_d     = ptr_q;
        if (hs) ptr_d = (int'(win) == NUM_BANKS - 1) ? '0 : win + BANK_W'(1);
    end

    // ---------------- saturating completion counters ----------------
    localparam logic [CNT_W+4:0] CNT_MAX = {5'b0, {CNT_W{1'b1}}};
    logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d, ack_cnt_q, ack_cnt_d;
    logic [CNT_W+4:0] rd_sum, ack_sum;

    always_comb begin
        rd_sum  = {5'b0, rd_cnt_q};
        ack_sum = {5'b0, ack_cnt_q};
        for (int i = 0; i < NUM_BANKS; i++) begin
            rd_sum  = rd_sum  + (CNT_W+5)'(rd_done_vec[i]);
            ack_sum = ack_sum + (CNT_W+5)'(ack_done_vec[i]);
        end
        rd_cnt_d  = (rd_sum  > CNT_MAX) ? {CNT_W{1'b1}} : rd_sum[CNT_W-1:0];
        ack_cnt_d = (ack_sum > CNT_MAX) ? {CNT_W{1'b1}} : ack_sum[CNT_W-1:0];
    end

    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            ptr_q     <= '0;
            rd_cnt_q  <= '0;
            ack_cnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            rd_cnt_q  <= rd_cnt_d;
            ack_cnt_q <= ack_cnt_d;
        end
    end

    assign rd_cnt  = rd_cnt_q;
    assign ack_cnt = ack_cnt_q;

endmodule

// File: tb/tb_l2_sio_resp_chk.sv
// Scoreboard bench for l2_sio_resp_chk: expected events are queued when the
// stimulus is driven and compared in order as the DUT hands them over.
module tb_l2_sio_resp_chk;

    localparam int NB = 8;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst_l;
    logic              mon_en;
    logic [NB-1:0]     ctag;
    logic [NB*DW-1:0]  data;
    logic [NB*2-1:0]   par;
    logic [NB-1:0]     ue;
    logic              evt_rdy;
    logic              evt_vld;
    logic [2:0]        evt_bank;
    logic [2:0]        evt_code;
    logic [DW-1:0]     evt_hdr;
    logic [15:0]       rd_cnt, ack_cnt;
    logic [NB-1:0]     evt_ovf;

    logic              s_evt_vld;
    logic [2:0]        s_evt_bank, s_evt_code;
    logic [DW-1:0]     s_evt_hdr;
    logic [1:0]        s_rd_cnt, s_ack_cnt;
    logic [NB-1:0]     s_evt_ovf;

    always #5 clk = ~clk;

    l2_sio_resp_chk u_dut (
        .iol2clk(clk), .rst_l(rst_l), .mon_en(mon_en),
        .l2b_ctag_vld(ctag), .l2b_data(data), .l2b_parity(par), .l2b_ue_err(ue),
        .evt_vld(evt_vld), .evt_rdy(evt_rdy), .evt_bank(evt_bank),
        .evt_code(evt_code), .evt_hdr(evt_hdr),
        .rd_cnt(rd_cnt), .ack_cnt(ack_cnt), .evt_ovf(evt_ovf)
    );

    l2_sio_resp_chk #(.CNT_W(2)) u_sat (
        .iol2clk(clk), .rst_l(rst_l), .mon_en(mon_en),
        .l2b_ctag_vld(ctag), .l2b_data(data), .l2b_parity(par), .l2b_ue_err(ue),
        .evt_vld(s_evt_vld), .evt_rdy(evt_rdy), .evt_bank(s_evt_bank),
        .evt_code(s_evt_code), .evt_hdr(s_evt_hdr),
        .rd_cnt(s_rd_cnt), .ack_cnt(s_ack_cnt), .evt_ovf(s_evt_ovf)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        int          bank;
        int          code;
        logic [31:0] hdr;
    } exp_t;

    exp_t sb[$];
    exp_t got;

    task automatic push(input int b, input int c, input logic [31:0] h);
        exp_t e;
        e.bank = b; e.code = c; e.hdr = h;
        sb.push_back(e);
    endtask

    // Compare on the falling edge; the handshake completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_l && evt_vld && evt_rdy) begin
            if (sb.size() == 0) begin
                check("unexpected_evt", {61'd0, evt_code}, 64'hFF);
            end else begin
                got = sb.pop_front();
                $display("evt bank %0d code %0d hdr %08h (exp bank %0d code %0d hdr %08h)",
                         evt_bank, evt_code, evt_hdr, got.bank, got.code, got.hdr);
                check("evt_bank", 64'(evt_bank), 64'(got.bank));
                check("evt_code", 64'(evt_code), 64'(got.code));
                check("evt_hdr",  64'(evt_hdr),  64'(got.hdr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        ctag = '0; ue = '0; data = '0; par = '0;
    endtask

    task automatic send_hdr(input int b, input logic [31:0] h);
        clr();
        ctag[b] = 1'b1;
        data[b*DW +: DW] = h;
        step();
        clr();
    endtask

    // Beats of 0x0000_FFFF with parity 00 (correct); beat 'bad' carries 0x1 with parity 00.
    task automatic send_beats(input int b, input int n, input int bad);
        for (int i = 0; i < n; i++) begin
            clr();
            data[b*DW +: DW] = (i == bad) ? 32'h0000_0001 : 32'h0000_FFFF;
            par[b*2 +: 2]    = 2'b00;
            step();
        end
        clr();
    endtask

    task automatic drain(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && sb.size() > 0; i++) step();
        check(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vld"},  64'(evt_vld),  64'd0);
        check({tag, "_bank"}, 64'(evt_bank), 64'd0);
        check({tag, "_code"}, 64'(evt_code), 64'd0);
        check({tag, "_hdr"},  64'(evt_hdr),  64'd0);
        check({tag, "_rd"},   64'(rd_cnt),   64'd0);
        check({tag, "_ack"},  64'(ack_cnt),  64'd0);
        check({tag, "_ovf"},  64'(evt_ovf),  64'd0);
    endtask

    task automatic do_reset();
        rst_l = 1'b0;
        step();
        rst_l = 1'b1;
        sb.delete();
    endtask

    initial begin
        rst_l = 1'b0; mon_en = 1'b1; evt_rdy = 1'b1;
        clr();
        step(); step();
        check_reset_outputs("reset");
        rst_l = 1'b1;
        step();

        // Read response on bank 0: RD_DONE appears exactly BEATS+1 cycles after the header.
        push(0, 0, 32'h0000_0001);
        send_hdr(0, 32'h0000_0001);
        send_beats(0, 15, -1);
        check("rd_not_early", 64'(evt_vld), 64'd0);
        send_beats(0, 1, -1);
        check("rd_vld_h17", 64'(evt_vld), 64'd1);
        check("rd_cnt_1", 64'(rd_cnt), 64'd1);
        drain("drain_rd", 20);

        // Ack on bank 3, visible one cycle after the header.
        push(3, 1, 32'h8000_0000);
        send_hdr(3, 32'h8000_0000);
        check("ack_vld_h1", 64'(evt_vld), 64'd1);
        check("ack_cnt_1", 64'(ack_cnt), 64'd1);
        check("ack_rd_hold", 64'(rd_cnt), 64'd1);
        drain("drain_ack", 20);

        // Parity error on beat 4 of bank 5; response still completes.
        push(5, 2, 32'h0000_0055);
        push(5, 0, 32'h0000_0055);
        send_hdr(5, 32'h0000_0055);
        send_beats(5, 16, 4);
        drain("drain_par", 20);
        check("rd_cnt_par", 64'(rd_cnt), 64'd2);

        // Header arriving at beat 7 on bank 2 abandons the first response.
        push(2, 4, 32'h0000_2222);
        push(2, 0, 32'h0000_2222);
        send_hdr(2, 32'h0000_0022);
        send_beats(2, 7, -1);
        send_hdr(2, 32'h0000_2222);
        send_beats(2, 16, -1);
        drain("drain_proto", 20);
        check("rd_cnt_proto", 64'(rd_cnt), 64'd3);

        // Uncorrectable error on an idle bank that never saw a header.
        push(6, 3, 32'h0);
        clr(); ue[6] = 1'b1; step(); clr();
        drain("drain_ue", 20);

        // mon_en dropped mid-response: no event, no count.
        send_hdr(4, 32'h0000_0044);
        send_beats(4, 5, -1);
        mon_en = 1'b0;
        send_beats(4, 11, -1);
        mon_en = 1'b1;
        step(); step();
        check("monen_no_evt", 64'(evt_vld), 64'd0);
        check("monen_rd_cnt", 64'(rd_cnt), 64'd3);

        // All banks ack together while the consumer stalls; second ack on bank 0 overflows.
        do_reset();
        evt_rdy = 1'b0;
        clr();
        for (int b = 0; b < NB; b++) begin
            ctag[b] = 1'b1;
            data[b*DW +: DW] = 32'h8000_0000 | 32'(b);
            push(b, 1, 32'h8000_0000 | 32'(b));
        end
        step();
        clr();
        check("all_ack_cnt", 64'(ack_cnt), 64'd8);
        check("stall_bank", 64'(evt_bank), 64'd0);
        send_hdr(0, 32'h8000_00AA);
        check("ovf_bank0", 64'(evt_ovf), 64'h01);
        check("stall_hdr_stable", 64'(evt_hdr), 64'h8000_0000);
        evt_rdy = 1'b1;
        drain("drain_all_ack", 30);
        check("ovf_sticky", 64'(evt_ovf), 64'h01);
        check("sat_after_9", 64'(s_ack_cnt), 64'd3);

        // Five acks: 16-bit counter reaches 5, 2-bit counter saturates at 3.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            push(1, 1, 32'h8000_0100 | 32'(k));
            send_hdr(1, 32'h8000_0100 | 32'(k));
        end
        drain("drain_sat", 20);
        check("sat_ack_cnt", 64'(s_ack_cnt), 64'd3);
        check("wide_ack_cnt", 64'(ack_cnt), 64'd5);

        // Reset asserted mid-read with a pending event and an overflow flag set.
        evt_rdy = 1'b0;
        send_hdr(7, 32'h8000_0007);
        send_hdr(7, 32'h8000_0008);
        check("pre_rst_ovf", 64'(evt_ovf), 64'h80);
        send_hdr(0, 32'h0000_0077);
        send_beats(0, 5, -1);
        #2 rst_l = 1'b0;
        #1;
        check_reset_outputs("midrst");
        step();
        rst_l = 1'b1;
        evt_rdy = 1'b1;
        send_beats(0, 11, -1);
        step(); step();
        check("post_rst_no_evt", 64'(evt_vld), 64'd0);
        check("post_rst_rd_cnt", 64'(rd_cnt), 64'd0);
        check("sb_final", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
